// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the pipelined control unit.
//   ctrl_t   - 24-bit packed control bundle carried through ID/EX, EX/MEM, MEM/WB
//   OP_*/FN_* - MIPS opcode and funct encodings recognised by the decoder
//   BC_*     - branch comparison codes handed to the branch unit
//   state_t  - HALT drain state machine encoding
package ctrl_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       is_signed;
    logic       reg_dst;
    logic       jump;
    logic       jmp_source;
    logic       jmp_link;
    logic       branch;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
    logic [1:0] alu_sel;
    logic [5:0] alu_code;
    logic [5:0] branch_code;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_HALT  = 6'h3F;

  localparam logic [5:0] BC_BEQ  = 6'h03;
  localparam logic [5:0] BC_BNE  = 6'h04;
  localparam logic [5:0] BC_BLEZ = 6'h07;
  localparam logic [5:0] BC_BGTZ = 6'h0F;
  localparam logic [5:0] BC_BGEZ = 6'h11;
  localparam logic [5:0] BC_BLTZ = 6'h13;

  localparam logic [5:0] ALU_RTYPE  = 6'h02;
  localparam logic [5:0] ALU_BRANCH = 6'h3F;
  localparam logic [1:0] ALU_SEL_IMM = 2'b01;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: purely combinational ID-stage decode.
//   opcode_i, funct_i  - IR[31:26], IR[5:0]
//   rt_i, rd_i         - IR[20:16], IR[15:11]
//   ctrl_o             - control bundle for the instruction
//   dst_o              - resolved destination register (rd, rt, all-ones for JAL, else 0)
//   rt_src_o           - rt is read as a source operand
//   is_halt_o          - instruction is HALT
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [5:0]      opcode_i,
  input  logic [5:0]      funct_i,
  input  logic [RA_W-1:0] rt_i,
  input  logic [RA_W-1:0] rd_i,
  output ctrl_t           ctrl_o,
  output logic [RA_W-1:0] dst_o,
  output logic            rt_src_o,
  output logic            is_halt_o
);

  always_comb begin
    ctrl_o    = '0;
    dst_o     = '0;
    rt_src_o  = 1'b0;
    is_halt_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.alu_code   = ALU_RTYPE;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.reg_write  = !(funct_i inside {FN_MULT, FN_MULTU, FN_JR});
        ctrl_o.jump       = (funct_i == FN_JR);
        ctrl_o.jmp_source = (funct_i == FN_JR);
        dst_o             = rd_i;
        rt_src_o          = 1'b1;
        is_halt_o         = (funct_i == FN_HALT);
      end
      OP_LW: begin
        ctrl_o.is_signed  = 1'b1;
        ctrl_o.alu_sel    = ALU_SEL_IMM;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        dst_o             = rt_i;
      end
      OP_SW: begin
        ctrl_o.is_signed = 1'b1;
        ctrl_o.alu_sel   = ALU_SEL_IMM;
        ctrl_o.mem_write = 1'b1;
        rt_src_o         = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        ctrl_o.branch   = 1'b1;
        ctrl_o.alu_code = ALU_BRANCH;
        case (opcode_i)
          OP_BEQ:  ctrl_o.branch_code = BC_BEQ;
          OP_BNE:  ctrl_o.branch_code = BC_BNE;
          OP_BLEZ: ctrl_o.branch_code = BC_BLEZ;
          default: ctrl_o.branch_code = BC_BGTZ;
        endcase
        rt_src_o = (opcode_i == OP_BEQ) || (opcode_i == OP_BNE);
      end
      OP_REGIMM: begin
        // rt selects the comparison; unknown rt decodes as a full NOP
        if (rt_i == RA_W'(0) || rt_i == RA_W'(1)) begin
          ctrl_o.branch      = 1'b1;
          ctrl_o.alu_code    = ALU_BRANCH;
          ctrl_o.branch_code = (rt_i == RA_W'(0)) ? BC_BLTZ : BC_BGEZ;
        end
      end
      OP_J: begin
        ctrl_o.jump = 1'b1;
      end
      OP_JAL: begin
        ctrl_o.jump      = 1'b1;
        ctrl_o.jmp_link  = 1'b1;
        ctrl_o.reg_write = 1'b1;
        dst_o            = '1;
      end
      default: begin
        ctrl_o.alu_sel   = ALU_SEL_IMM;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_code  = opcode_i;
        dst_o            = rt_i;
      end
    endcase
  end

endmodule

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: pipelined control path between IF/ID and the datapath stage registers.
//   clk_i, rst_i              - clock; synchronous active-low reset
//   id_valid_i, id_*_i        - instruction fields currently in IF/ID
//   ex_redirect_i             - branch unit redirects PC from the instruction in EX
//   id_stall_o, if_flush_o    - hold PC/IF-ID, squash IF-ID
//   {ex,mem,wb}_{valid,ctrl,dst}_o - per-stage control state
//   halted_o                  - pipeline drained after HALT
// Optional build macro CTRL_PERF_CNT_EN adds stall_cnt_o / flush_cnt_o event counters.
//
// state   | meaning
// RUN     | normal issue, hazard and redirect handling
// DRAIN   | HALT accepted; bubbles issued while EX/MEM/WB empty
// HALTED  | pipeline empty, ID held until reset
module pipe_control_unit
  import ctrl_pkg::*;
#(
  parameter int RA_W       = 5,
  parameter int HALT_DRAIN = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            id_valid_i,
  input  logic [5:0]      id_opcode_i,
  input  logic [5:0]      id_funct_i,
  input  logic [RA_W-1:0] id_rs_i,
  input  logic [RA_W-1:0] id_rt_i,
  input  logic [RA_W-1:0] id_rd_i,
  input  logic            ex_redirect_i,
  output logic            id_stall_o,
  output logic            if_flush_o,
  output logic            ex_valid_o,
  output logic            mem_valid_o,
  output logic            wb_valid_o,
  output ctrl_t           ex_ctrl_o,
  output ctrl_t           mem_ctrl_o,
  output ctrl_t           wb_ctrl_o,
  output logic [RA_W-1:0] ex_dst_o,
  output logic [RA_W-1:0] mem_dst_o,
  output logic [RA_W-1:0] wb_dst_o,
`ifdef CTRL_PERF_CNT_EN
  output logic [31:0]     stall_cnt_o,
  output logic [31:0]     flush_cnt_o,
`endif
  output logic            halted_o
);

  localparam int CNT_W = $clog2(HALT_DRAIN + 1);

  ctrl_t           dec_ctrl;
  logic [RA_W-1:0] dec_dst;
  logic            dec_rt_src;
  logic            dec_is_halt;

  ctrl_decoder #(.RA_W(RA_W)) u_dec (
    .opcode_i  (id_opcode_i),
    .funct_i   (id_funct_i),
    .rt_i      (id_rt_i),
    .rd_i      (id_rd_i),
    .ctrl_o    (dec_ctrl),
    .dst_o     (dec_dst),
    .rt_src_o  (dec_rt_src),
    .is_halt_o (dec_is_halt)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            ex_valid_q, mem_valid_q, wb_valid_q;
  ctrl_t           ex_ctrl_q, mem_ctrl_q, wb_ctrl_q;
  logic [RA_W-1:0] ex_dst_q, mem_dst_q, wb_dst_q;

  logic in_run, redirect, load_use, halt_accept, issue;

  // Redirects only matter while running; DRAIN/HALTED already hold ID.
  assign in_run   = (state_q == ST_RUN);
  assign redirect = in_run && ex_redirect_i;

  assign load_use = id_valid_i && ex_valid_q && ex_ctrl_q.mem_read && (ex_dst_q != '0) &&
                    ((ex_dst_q == id_rs_i) || (dec_rt_src && (ex_dst_q == id_rt_i)));

  assign halt_accept = in_run && id_valid_i && dec_is_halt && !load_use && !ex_redirect_i;
  assign issue       = in_run && id_valid_i && !dec_is_halt && !load_use && !ex_redirect_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (halt_accept) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(HALT_DRAIN);
        end
      end
      ST_DRAIN: begin
        // HALTED is entered on the same edge the counter reaches zero
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_HALTED;
          cnt_d   = '0;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    id_stall_o = 1'b0;
    if_flush_o = 1'b0;
    halted_o   = 1'b0;
    if (rst_i) begin
      if_flush_o = redirect;
      id_stall_o = !redirect && (load_use || !in_run);
      halted_o   = (state_q == ST_HALTED);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      mem_ctrl_q  <= '0;
      wb_ctrl_q   <= '0;
      ex_dst_q    <= '0;
      mem_dst_q   <= '0;
      wb_dst_q    <= '0;
    end else begin
      ex_valid_q  <= issue;
      ex_ctrl_q   <= issue ? dec_ctrl : '0;
      ex_dst_q    <= issue ? dec_dst : '0;
      mem_valid_q <= ex_valid_q;
      mem_ctrl_q  <= ex_ctrl_q;
      mem_dst_q   <= ex_dst_q;
      wb_valid_q  <= mem_valid_q;
      wb_ctrl_q   <= mem_ctrl_q;
      wb_dst_q    <= mem_dst_q;
    end
  end

  assign ex_valid_o  = ex_valid_q;
  assign mem_valid_o = mem_valid_q;
  assign wb_valid_o  = wb_valid_q;
  assign ex_ctrl_o   = ex_ctrl_q;
  assign mem_ctrl_o  = mem_ctrl_q;
  assign wb_ctrl_o   = wb_ctrl_q;
  assign ex_dst_o    = ex_dst_q;
  assign mem_dst_o   = mem_dst_q;
  assign wb_dst_o    = wb_dst_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        stall_evt;

  assign stall_evt = in_run && load_use && !ex_redirect_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (state_q != ST_HALTED) begin
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redirect && (flush_cnt_q != '1))  flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_control_unit.sv
// Self-checking bench for pipe_control_unit (default build; CTRL_PERF_CNT_EN adds counter checks).
module tb_pipe_control_unit;

  typedef struct packed {
    logic        v;
    logic [23:0] c;
    logic [4:0]  d;
  } stg_t;

  localparam logic [23:0] C_ADDU  = 24'hA00080;
  localparam logic [23:0] C_LW    = 24'hC15000;
  localparam logic [23:0] C_SW    = 24'h409000;
  localparam logic [23:0] C_BEQ   = 24'h020FC3;
  localparam logic [23:0] C_ADDI  = 24'h801200;
  localparam stg_t        BUBBLE  = '0;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        ex_redirect;
  logic        id_stall, if_flush;
  logic        ex_valid, mem_valid, wb_valid;
  logic [23:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0]  ex_dst, mem_dst, wb_dst;
  logic        halted;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  stg_t ex_obs, mem_obs, wb_obs;
  assign ex_obs  = {ex_valid, ex_ctrl, ex_dst};
  assign mem_obs = {mem_valid, mem_ctrl, mem_dst};
  assign wb_obs  = {wb_valid, wb_ctrl, wb_dst};

  stg_t exp_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  pipe_control_unit #(.RA_W(5), .HALT_DRAIN(3)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .id_valid_i    (id_valid),
    .id_opcode_i   (id_opcode),
    .id_funct_i    (id_funct),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_rd_i       (id_rd),
    .ex_redirect_i (ex_redirect),
    .id_stall_o    (id_stall),
    .if_flush_o    (if_flush),
    .ex_valid_o    (ex_valid),
    .mem_valid_o   (mem_valid),
    .wb_valid_o    (wb_valid),
    .ex_ctrl_o     (ex_ctrl),
    .mem_ctrl_o    (mem_ctrl),
    .wb_ctrl_o     (wb_ctrl),
    .ex_dst_o      (ex_dst),
    .mem_dst_o     (mem_dst),
    .wb_dst_o      (wb_dst),
`ifdef CTRL_PERF_CNT_EN
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt),
`endif
    .halted_o      (halted)
  );

  // Inputs change 1 time unit after the rising edge; #1 more lets comb outputs settle.
  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic redir);
    id_valid = v; id_opcode = op; id_funct = fn;
    id_rs = rs; id_rt = rt; id_rd = rd; ex_redirect = redir;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stg_t exp;
    rst = 1'b0;
    drive(1'b1, 6'h23, 6'h00, 5'd0, 5'd5, 5'd0, 1'b1);
    step();
    step();
    vec_cnt++;
    if (id_stall !== 1'b0) begin err_cnt++; $display("FAIL rst_stall got=%b want=0", id_stall); end
    vec_cnt++;
    if (if_flush !== 1'b0) begin err_cnt++; $display("FAIL rst_flush got=%b want=0", if_flush); end
    vec_cnt++;
    if ({ex_obs, mem_obs, wb_obs} !== '0) begin
      err_cnt++; $display("FAIL rst_stages got ex=%h mem=%h wb=%h want all 0", ex_obs, mem_obs, wb_obs);
    end
    vec_cnt++;
    if (halted !== 1'b0) begin err_cnt++; $display("FAIL rst_halted got=%b want=0", halted); end
    idle();
    rst = 1'b1;
    step();
    exp = BUBBLE;
    vec_cnt++;
    if (ex_obs !== exp) begin err_cnt++; $display("FAIL rst_release_ex got=%h want=%h", ex_obs, exp); end
  endtask

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [23:0] c;
    logic [4:0]  d;
  } dec_t;

  task automatic test_decode();
    dec_t tbl [17];
    stg_t exp, p1, p2;
    tbl = '{
      '{6'h00, 6'h21, 5'd1, 5'd2, 5'd7,  24'hA00080, 5'd7},   // ADDU
      '{6'h00, 6'h08, 5'd3, 5'd0, 5'd4,  24'h380080, 5'd4},   // JR
      '{6'h00, 6'h18, 5'd1, 5'd2, 5'd0,  24'h200080, 5'd0},   // MULT
      '{6'h23, 6'h00, 5'd1, 5'd6, 5'd11, 24'hC15000, 5'd6},   // LW
      '{6'h2B, 6'h00, 5'd1, 5'd9, 5'd11, 24'h409000, 5'd0},   // SW
      '{6'h04, 6'h00, 5'd1, 5'd2, 5'd11, 24'h020FC3, 5'd0},   // BEQ
      '{6'h05, 6'h00, 5'd1, 5'd2, 5'd11, 24'h020FC4, 5'd0},   // BNE
      '{6'h06, 6'h00, 5'd1, 5'd0, 5'd11, 24'h020FC7, 5'd0},   // BLEZ
      '{6'h07, 6'h00, 5'd1, 5'd0, 5'd11, 24'h020FCF, 5'd0},   // BGTZ
      '{6'h01, 6'h00, 5'd1, 5'd0, 5'd11, 24'h020FD3, 5'd0},   // BLTZ
      '{6'h01, 6'h00, 5'd1, 5'd1, 5'd11, 24'h020FD1, 5'd0},   // BGEZ
      '{6'h01, 6'h00, 5'd1, 5'd2, 5'd11, 24'h000000, 5'd0},   // REGIMM other rt
      '{6'h02, 6'h00, 5'd0, 5'd0, 5'd11, 24'h100000, 5'd0},   // J
      '{6'h03, 6'h00, 5'd0, 5'd3, 5'd11, 24'h940000, 5'd31},  // JAL
      '{6'h08, 6'h00, 5'd1, 5'd5, 5'd11, 24'h801200, 5'd5},   // ADDI
      '{6'h0D, 6'h00, 5'd1, 5'd3, 5'd11, 24'h801340, 5'd3},   // ORI
      '{6'h00, 6'h19, 5'd1, 5'd2, 5'd10, 24'h200080, 5'd10}   // MULTU
    };
    p1 = BUBBLE;
    p2 = BUBBLE;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, tbl[i].op, tbl[i].fn, tbl[i].rs, tbl[i].rt, tbl[i].rd, 1'b0);
      exp_q.push_back({1'b1, tbl[i].c, tbl[i].d});
      step();
      exp = exp_q.pop_front();
      vec_cnt++;
      if (ex_obs !== exp) begin
        err_cnt++;
        $display("FAIL dec_ex[%0d] got v=%b c=%h d=%0d want v=%b c=%h d=%0d", i, ex_obs.v, ex_obs.c, ex_obs.d, exp.v, exp.c, exp.d);
      end
      if (i >= 1) begin
        vec_cnt++;
        if (mem_obs !== p1) begin err_cnt++; $display("FAIL dec_mem[%0d] got=%h want=%h", i, mem_obs, p1); end
      end
      if (i >= 2) begin
        vec_cnt++;
        if (wb_obs !== p2) begin err_cnt++; $display("FAIL dec_wb[%0d] got=%h want=%h", i, wb_obs, p2); end
      end
      p2 = p1;
      p1 = exp;
    end
    idle();
    step(); step(); step();
  endtask

  task automatic test_load_use();
    stg_t exp;
    drive(1'b1, 6'h23, 6'h00, 5'd0, 5'd5, 5'd0, 1'b0);
    exp_q.push_back({1'b1, C_LW, 5'd5});
    step();
    exp = exp_q.pop_front();
    vec_cnt++;
    if (ex_obs !== exp) begin err_cnt++; $display("FAIL lu_lw_ex got=%h want=%h", ex_obs, exp); end

    drive(1'b1, 6'h00, 6'h21, 5'd5, 5'd0, 5'd8, 1'b0);
    vec_cnt++;
    if (id_stall !== 1'b1) begin err_cnt++; $display("FAIL lu_stall got=%b want=1", id_stall); end
    exp_q.push_back(BUBBLE);
    step();
    exp = exp_q.pop_front();
    vec_cnt++;
    if (ex_obs !== exp) begin err_cnt++; $display("FAIL lu_bubble got=%h want=%h", ex_obs, exp); end
    vec_cnt++;
    if (id_stall !== 1'b0) begin err_cnt++; $display("FAIL lu_one_cycle got=%b want=0", id_stall); end
    exp_q.push_back({1'b1, C_ADDU, 5'd8});
    step();
    exp = exp_q.pop_front();
    vec_cnt++;
    if (ex_obs !== exp) begin err_cnt++; $display("FAIL lu_late_issue got=%h want=%h", ex_obs, exp); end

    drive(1'b1, 6'h23, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    step();
    drive(1'b1, 6'h00, 6'h21, 5'd0, 5'd0, 5'd8, 1'b0);
    vec_cnt++;
    if (id_stall !== 1'b0) begin err_cnt++; $display("FAIL lu_r0 got=%b want=0", id_stall); end
    exp_q.push_back({1'b1, C_ADDU, 5'd8});
    step();
    exp = exp_q.pop_front();
    vec_cnt++;
    if (ex_obs !== exp) begin err_cnt++; $display("FAIL lu_r0_issue got=%h want=%h", ex_obs, exp); end

    drive(1'b1, 6'h23, 6'h00, 5'd0, 5'd5, 5'd0, 1'b0);
    step();
    drive(1'b1, 6'h2B, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0);
    vec_cnt++;
    if (id_stall !== 1'b1) begin err_cnt++; $display("FAIL lu_sw_rt got=%b want=1", id_stall); end
    exp_q.push_back(BUBBLE);
    step();
    exp = exp_q.pop_front();
    vec_cnt++;
    if (ex_obs !== exp) begin err_cnt++; $display("FAIL lu_sw_bubble got=%h want=%h", ex_obs, exp); end
    exp_q.push_back({1'b1, C_SW, 5'd0});
    step();
    exp = exp_q.pop_front();
    vec_cnt++;
    if (ex_obs !== exp) begin err_cnt++; $display("FAIL lu_sw_issue got=%h want=%h", ex_obs, exp); end

    drive(1'b1, 6'h23, 6'h00, 5'd0, 5'd5, 5'd0, 1'b0);
    step();
    drive(1'b1, 6'h08, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0);
    vec_cnt++;
    if (id_stall !== 1'b0) begin err_cnt++; $display("FAIL lu_addi_rt got=%b want=0", id_stall); end
    exp_q.push_back({1'b1, C_ADDI, 5'd5});
    step();
    exp = exp_q.pop_front();
    vec_cnt++;
    if (ex_obs !== exp) begin err_cnt++; $display("FAIL lu_addi_issue got=%h want=%h", ex_obs, exp); end
    idle();
    step();
`ifdef CTRL_PERF_CNT_EN
    vec_cnt++;
    if (stall_cnt !== 32'd2) begin err_cnt++; $display("FAIL perf_stall got=%0d want=2", stall_cnt); end
`endif
  endtask

  task automatic test_redirect();
    stg_t exp;
    drive(1'b1, 6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0);
    exp_q.push_back({1'b1, C_BEQ, 5'd0});
    step();
    exp = exp_q.pop_front();
    vec_cnt++;
    if (ex_obs !== exp) begin err_cnt++; $display("FAIL beq_ex got=%h want=%h", ex_obs, exp); end

    drive(1'b1, 6'h00, 6'h21, 5'd1, 5'd2, 5'd3, 1'b1);
    vec_cnt++;
    if (if_flush !== 1'b1) begin err_cnt++; $display("FAIL redir_flush got=%b want=1", if_flush); end
    vec_cnt++;
    if (id_stall !== 1'b0) begin err_cnt++; $display("FAIL redir_nostall got=%b want=0", id_stall); end
    exp_q.push_back(BUBBLE);
    step();
    exp = exp_q.pop_front();
    vec_cnt++;
    if (ex_obs !== exp) begin err_cnt++; $display("FAIL redir_squash got=%h want=%h", ex_obs, exp); end
    idle();
    step();

    drive(1'b1, 6'h23, 6'h00, 5'd0, 5'd5, 5'd0, 1'b0);
    step();
    drive(1'b1, 6'h00, 6'h21, 5'd5, 5'd0, 5'd8, 1'b1);
    vec_cnt++;
    if ({if_flush, id_stall} !== 2'b10) begin
      err_cnt++; $display("FAIL lu_redir flush/stall got=%b%b want=10", if_flush, id_stall);
    end
    exp_q.push_back(BUBBLE);
    step();
    exp = exp_q.pop_front();
    vec_cnt++;
    if (ex_obs !== exp) begin err_cnt++; $display("FAIL lu_redir_squash got=%h want=%h", ex_obs, exp); end

    drive(1'b1, 6'h00, 6'h3F, 5'd0, 5'd0, 5'd0, 1'b1);
    vec_cnt++;
    if (if_flush !== 1'b1) begin err_cnt++; $display("FAIL halt_redir_flush got=%b want=1", if_flush); end
    step();
    idle();
    vec_cnt++;
    if ({id_stall, halted, ex_valid} !== 3'b000) begin
      err_cnt++; $display("FAIL halt_redir_run stall/halted/ex_valid got=%b%b%b want=000", id_stall, halted, ex_valid);
    end
    step();
`ifdef CTRL_PERF_CNT_EN
    vec_cnt++;
    if (flush_cnt !== 32'd3) begin err_cnt++; $display("FAIL perf_flush got=%0d want=3", flush_cnt); end
`endif
  endtask

  task automatic test_halt();
    stg_t exp;
    drive(1'b1, 6'h00, 6'h21, 5'd1, 5'd2, 5'd9, 1'b0);
    step();
    drive(1'b1, 6'h00, 6'h3F, 5'd0, 5'd0, 5'd0, 1'b0);
    vec_cnt++;
    if (id_stall !== 1'b0) begin err_cnt++; $display("FAIL halt_accept_stall got=%b want=0", id_stall); end
    step();  // acceptance edge
    drive(1'b1, 6'h00, 6'h21, 5'd1, 5'd2, 5'd10, 1'b0);
    vec_cnt++;
    if (ex_obs !== BUBBLE) begin err_cnt++; $display("FAIL halt_ex_bubble got=%h want=0", ex_obs); end
    exp = {1'b1, C_ADDU, 5'd9};
    vec_cnt++;
    if (mem_obs !== exp) begin err_cnt++; $display("FAIL halt_prev_mem got=%h want=%h", mem_obs, exp); end
    vec_cnt++;
    if ({id_stall, halted} !== 2'b10) begin err_cnt++; $display("FAIL drain_1 stall/halted got=%b%b want=10", id_stall, halted); end
    step();
    vec_cnt++;
    if (wb_obs !== exp) begin err_cnt++; $display("FAIL halt_prev_wb got=%h want=%h", wb_obs, exp); end
    vec_cnt++;
    if ({id_stall, halted, ex_valid} !== 3'b100) begin
      err_cnt++; $display("FAIL drain_2 stall/halted/ex_valid got=%b%b%b want=100", id_stall, halted, ex_valid);
    end
    step();
    vec_cnt++;
    if ({id_stall, halted} !== 2'b10) begin err_cnt++; $display("FAIL drain_3 stall/halted got=%b%b want=10", id_stall, halted); end
    step();
    vec_cnt++;
    if ({id_stall, halted} !== 2'b11) begin err_cnt++; $display("FAIL halted_at_3 stall/halted got=%b%b want=11", id_stall, halted); end
    vec_cnt++;
    if ({ex_valid, mem_valid, wb_valid} !== 3'b000) begin
      err_cnt++; $display("FAIL halted_empty got=%b%b%b want=000", ex_valid, mem_valid, wb_valid);
    end
    drive(1'b1, 6'h00, 6'h21, 5'd1, 5'd2, 5'd10, 1'b1);
    vec_cnt++;
    if ({if_flush, id_stall} !== 2'b01) begin
      err_cnt++; $display("FAIL halted_ignore_redir flush/stall got=%b%b want=01", if_flush, id_stall);
    end
    step();
    vec_cnt++;
    if ({halted, ex_valid} !== 2'b10) begin err_cnt++; $display("FAIL halted_hold halted/ex_valid got=%b%b want=10", halted, ex_valid); end
    rst = 1'b0;
    idle();
    step();
    rst = 1'b1;
    #1;
    vec_cnt++;
    if ({halted, id_stall} !== 2'b00) begin err_cnt++; $display("FAIL halted_reset halted/stall got=%b%b want=00", halted, id_stall); end
  endtask

  task automatic test_reset_mid_drain();
    stg_t exp;
    drive(1'b1, 6'h00, 6'h3F, 5'd0, 5'd0, 5'd0, 1'b0);
    step();
    idle();
    step();
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (id_stall !== 1'b0) begin err_cnt++; $display("FAIL mid_drain_rst_stall got=%b want=0", id_stall); end
    step();
    rst = 1'b1;
    #1;
    vec_cnt++;
    if ({halted, id_stall, ex_valid, mem_valid, wb_valid} !== 5'b00000) begin
      err_cnt++; $display("FAIL mid_drain_run got=%b%b%b%b%b want=00000", halted, id_stall, ex_valid, mem_valid, wb_valid);
    end
    drive(1'b1, 6'h00, 6'h21, 5'd1, 5'd2, 5'd12, 1'b0);
    exp_q.push_back({1'b1, C_ADDU, 5'd12});
    step();
    exp = exp_q.pop_front();
    vec_cnt++;
    if (ex_obs !== exp) begin err_cnt++; $display("FAIL mid_drain_issue got=%h want=%h", ex_obs, exp); end
    idle();
    step(); step(); step(); step();
    vec_cnt++;
    if ({halted, id_stall} !== 2'b00) begin err_cnt++; $display("FAIL mid_drain_no_halt got=%b%b want=00", halted, id_stall); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_decode();
    test_load_use();
    test_redirect();
    test_halt();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
